// File: rtl/clk_div_pkg.sv
// Shared encodings for the divided-clock checker: FSM states and fault codes.
package clk_div_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        MEASURE = 3'd2,
        LOCKED  = 3'd3,
        FAULT   = 3'd4
    } state_t;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISMATCH = 2'b01;
    localparam logic [1:0] FC_STUCK    = 2'b10;

endpackage

// File: rtl/clk_div_checker_edge_counter.sv
// Edge detector on the sampled divided clock plus a saturating half-period counter.
module edge_counter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             divClk,
    output logic             divEdge,
    output logic [WIDTH-1:0] meas,
    output logic             timeoutHit
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] TO_LAST = WIDTH'(TIMEOUT - 1);

    logic             divQ;
    logic [WIDTH-1:0] cnt;

    assign divEdge    = divClk ^ divQ;
    // cnt counts cycles since the previous edge minus one, so the edge cycle itself adds one
    assign meas       = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign timeoutHit = !divEdge && (cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divQ <= 1'b0;
            cnt  <= '0;
        end else begin
            divQ <= divClk;
            if (clr || divEdge)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clk_div_checker.sv
// Checks a synchronous divided clock: measures each half-period, locks after a
// run of matches, and raises a sticky fault on a period mismatch or a stuck clock.
module clk_div_checker
    import clk_div_pkg::*;
#(
    parameter int EXP_HALF = 3,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 16,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             divClk,
    input  logic             clrErr,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       faultCode,
    output logic [WIDTH-1:0] halfPeriod,
    output logic             measValid
);

    localparam int               MW     = $clog2(LOCK_CNT + 1);
    localparam logic [MW-1:0]    LOCK_V = MW'(LOCK_CNT);
    localparam logic [WIDTH-1:0] EXP_V  = WIDTH'(EXP_HALF);

    state_t           state, state_n;
    logic [MW-1:0]    matchCnt, match_n, match_inc;
    logic             locked_n, fault_n, mv_n;
    logic [1:0]       fc_n;
    logic [WIDTH-1:0] hp_n;

    logic             divEdge, timeoutHit;
    logic [WIDTH-1:0] meas;

    edge_counter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) u_edge (
        .clk        (clk),
        .rst        (rst),
        .clr        (state == IDLE),
        .divClk     (divClk),
        .divEdge    (divEdge),
        .meas       (meas),
        .timeoutHit (timeoutHit)
    );

    assign match_inc = matchCnt + 1'b1;

    always_comb begin
        state_n = state;
        match_n = matchCnt;
        fault_n = fault;
        fc_n    = faultCode;
        hp_n    = halfPeriod;
        mv_n    = 1'b0;
        if (!en) begin
            state_n = IDLE;
            match_n = '0;
            fault_n = 1'b0;
            fc_n    = FC_NONE;
        end else begin
            case (state)
                IDLE: state_n = ARM;
                ARM: if (divEdge) begin
                    state_n = MEASURE;
                    match_n = '0;
                end
                MEASURE, LOCKED: begin
                    if (divEdge) begin
                        mv_n = 1'b1;
                        hp_n = meas;
                        if (state == LOCKED) begin
                            if (meas != EXP_V) begin
                                state_n = FAULT;
                                fault_n = 1'b1;
                                fc_n    = FC_MISMATCH;
                            end
                        end else if (meas == EXP_V) begin
                            match_n = match_inc;
                            if (match_inc == LOCK_V)
                                state_n = LOCKED;
                        end else begin
                            match_n = '0;
                        end
                    end else if (timeoutHit) begin
                        state_n = FAULT;
                        fault_n = 1'b1;
                        fc_n    = FC_STUCK;
                    end
                end
                FAULT: if (clrErr) begin
                    state_n = ARM;
                    fault_n = 1'b0;
                    fc_n    = FC_NONE;
                end
                default: state_n = IDLE;
            endcase
        end
        locked_n = (state_n == LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            matchCnt   <= '0;
            locked     <= 1'b0;
            fault      <= 1'b0;
            faultCode  <= FC_NONE;
            halfPeriod <= '0;
            measValid  <= 1'b0;
        end else begin
            state      <= state_n;
            matchCnt   <= match_n;
            locked     <= locked_n;
            fault      <= fault_n;
            faultCode  <= fc_n;
            halfPeriod <= hp_n;
            measValid  <= mv_n;
        end
    end

endmodule

// File: tb/tb_clk_div_checker.sv
// Directed bench for clk_div_checker: timestamp-based reference model compared
// every cycle, plus literal checks at the points of interest.
module tb_clk_div_checker;

    localparam int EXP_HALF = 3;
    localparam int LOCK_CNT = 4;
    localparam int TIMEOUT  = 16;
    localparam int WIDTH    = 8;

    localparam int MD_IDLE  = 0;
    localparam int MD_ARM   = 1;
    localparam int MD_MEAS  = 2;
    localparam int MD_LOCK  = 3;
    localparam int MD_FAULT = 4;

    logic clk = 1'b0, rst = 1'b0, en = 1'b0, divClk = 1'b0, clrErr = 1'b0;
    logic             locked, fault, measValid;
    logic [1:0]       faultCode;
    logic [WIDTH-1:0] halfPeriod;

    int vectors = 0, miscompares = 0;

    int mode = 0, good = 0, lastEdge = 0, cyc = 0, m = 0;
    bit prevDiv = 0, ev = 0;
    bit e_locked = 0, e_fault = 0, e_mv = 0;
    int e_fc = 0, e_hp = 0;

    int pat [6] = '{3, 3, 5, 3, 3, 3};

    clk_div_checker #(
        .EXP_HALF(EXP_HALF), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT), .WIDTH(WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .divClk     (divClk),
        .clrErr     (clrErr),
        .locked     (locked),
        .fault      (fault),
        .faultCode  (faultCode),
        .halfPeriod (halfPeriod),
        .measValid  (measValid)
    );

    always #5 clk = ~clk;

    // Model: half-period is the distance between edge timestamps
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mode = MD_IDLE; good = 0; lastEdge = 0; cyc = 0; prevDiv = 0;
            e_locked = 0; e_fault = 0; e_mv = 0; e_fc = 0; e_hp = 0;
        end else begin
            cyc++;
            ev = (divClk != prevDiv);
            prevDiv = divClk;
            e_mv = 0;
            if (!en) begin
                mode = MD_IDLE; good = 0; e_fault = 0; e_fc = 0;
            end else begin
                case (mode)
                    MD_IDLE: mode = MD_ARM;
                    MD_ARM: if (ev) begin mode = MD_MEAS; good = 0; end
                    MD_MEAS, MD_LOCK: begin
                        if (ev) begin
                            m = cyc - lastEdge;
                            e_mv = 1;
                            e_hp = m;
                            if (mode == MD_LOCK) begin
                                if (m != EXP_HALF) begin mode = MD_FAULT; e_fault = 1; e_fc = 1; end
                            end else if (m == EXP_HALF) begin
                                good++;
                                if (good == LOCK_CNT) mode = MD_LOCK;
                            end else begin
                                good = 0;
                            end
                        end else if (cyc - lastEdge == TIMEOUT) begin
                            mode = MD_FAULT; e_fault = 1; e_fc = 2;
                        end
                    end
                    MD_FAULT: if (clrErr) begin mode = MD_ARM; e_fault = 0; e_fc = 0; end
                    default: mode = MD_IDLE;
                endcase
            end
            if (ev) lastEdge = cyc;
            e_locked = (mode == MD_LOCK);
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (locked !== e_locked || fault !== e_fault || faultCode !== 2'(e_fc) ||
            halfPeriod !== WIDTH'(e_hp) || measValid !== e_mv) begin
            miscompares++;
            $display("FAIL model_cycle t=%0t got l=%b f=%b fc=%0d hp=%0d mv=%b expected l=%b f=%b fc=%0d hp=%0d mv=%b",
                     $time, locked, fault, faultCode, halfPeriod, measValid,
                     e_locked, e_fault, e_fc, e_hp, e_mv);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Toggle divClk n cycles after the previous toggle; optional clrErr pulse on the way
    task automatic half(input int n, input bit pulse);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clrErr = pulse && (i == 0);
        end
        divClk = ~divClk;
        clrErr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fault();
        @(negedge clk); clrErr = 1'b1;
        @(negedge clk); clrErr = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_locked", locked, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fc", faultCode, 0);
        chk("rst_hp", halfPeriod, 0);
        chk("rst_mv", measValid, 0);
        rst = 1'b0;
        @(negedge clk); en = 1'b1;

        // lock on a clean 3-cycle half-period
        half(3, 0);
        chk("arm_mv", measValid, 0);
        for (int i = 1; i <= 3; i++) begin
            half(3, 0);
            chk("acq_mv", measValid, 1);
            chk("acq_hp", halfPeriod, 3);
            chk("acq_locked", locked, 0);
        end
        half(3, 0);
        chk("lock_locked", locked, 1);
        chk("lock_fault", fault, 0);
        chk("model_lock", e_locked, 1);

        // one long half-period while locked
        half(4, 0);
        chk("mm_hp", halfPeriod, 4);
        chk("mm_mv", measValid, 1);
        chk("mm_locked", locked, 0);
        chk("mm_fault", fault, 1);
        chk("mm_fc", faultCode, 1);
        chk("model_mm_fc", e_fc, 1);

        // clear, relock, then clrErr while locked is ignored
        clear_fault();
        chk("clr_fault", fault, 0);
        chk("clr_fc", faultCode, 0);
        half(3, 0);
        chk("rearm_mv", measValid, 0);
        repeat (3) half(3, 0);
        chk("relock_pre", locked, 0);
        half(3, 0);
        chk("relock", locked, 1);
        half(3, 1);
        chk("clr_locked_locked", locked, 1);
        chk("clr_locked_fault", fault, 0);
        chk("clr_locked_hp", halfPeriod, 3);

        // stuck clock: fault exactly TIMEOUT cycles after the last edge
        for (int i = 1; i < TIMEOUT; i++) begin
            @(posedge clk); #1;
            chk("stuck_pre_fault", fault, 0);
        end
        @(posedge clk); #1;
        chk("stuck_fault", fault, 1);
        chk("stuck_fc", faultCode, 2);
        chk("stuck_locked", locked, 0);
        chk("stuck_mv", measValid, 0);

        // one mismatch during acquisition restarts the match run
        clear_fault();
        chk("clr2_fault", fault, 0);
        half(3, 0);
        foreach (pat[i]) begin
            half(pat[i], 0);
            chk("acq2_hp", halfPeriod, pat[i]);
            chk("acq2_locked", locked, 0);
            chk("acq2_fault", fault, 0);
        end
        half(3, 0);
        chk("acq2_lock", locked, 1);

        // async reset between clk edges
        @(negedge clk);
        #2 rst = 1'b1;
        en = 1'b0;
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_fault", fault, 0);
        chk("arst_mv", measValid, 0);
        chk("arst_hp", halfPeriod, 0);
        @(negedge clk); rst = 1'b0;
        repeat (4) begin
            half(3, 0);
            chk("idle_mv", measValid, 0);
            chk("idle_locked", locked, 0);
        end
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
